// File: rtl/sram_port_arbiter.sv
// Three-way round-robin arbiter in front of a single-port 72-bit packet SRAM.
// Supports a CPU lock mode that drains wr/rd traffic and then gives the CPU sole access.
module sram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_req,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0]   wr_wdata,
  output logic                               wr_gnt,
  input  logic                               rd_req,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic                               rd_gnt,
  output logic [DATA_WIDTH+CTRL_WIDTH-1:0]   rd_rdata,
  output logic                               rd_rvld,
  input  logic                               cpu_req,
  input  logic                               cpu_wen,
  input  logic [ADDR_WIDTH-1:0]              cpu_addr,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0]   cpu_wdata,
  output logic                               cpu_gnt,
  output logic [DATA_WIDTH+CTRL_WIDTH-1:0]   cpu_rdata,
  output logic                               cpu_rvld,
  input  logic                               cpu_lock,
  output logic                               locked,
  output logic [15:0]                        conflict_cnt,
  output logic                               sram_en,
  output logic                               sram_we,
  output logic [ADDR_WIDTH-1:0]              sram_addr,
  output logic [DATA_WIDTH+CTRL_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0]   sram_rdata
);

  localparam int unsigned WW = DATA_WIDTH + CTRL_WIDTH;

  typedef enum logic [1:0] {ST_ARB, ST_DRAIN, ST_LOCKED} state_t;
  typedef enum logic [1:0] {PT_WR, PT_RD, PT_CPU} ptr_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_WR, SEL_RD, SEL_CPU} sel_t;
  typedef enum logic [2:0] {TAG_NONE, TAG_WR, TAG_RD, TAG_CPU_WR, TAG_CPU_RD} tag_t;

  state_t                state_q, state_d;
  ptr_t                  ptr_q, ptr_d;
  tag_t                  tag1_q, tag1_d, tag2_q;
  logic [15:0]           cnt_q, cnt_d;
  logic                  sram_en_q, sram_en_d;
  logic                  sram_we_q, sram_we_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [WW-1:0]         sram_wdata_q, sram_wdata_d;
  sel_t                  sel;
  logic                  two_plus;

  assign two_plus = (wr_req & rd_req) | (wr_req & cpu_req) | (rd_req & cpu_req);

  // Pointer names the port with highest priority this cycle.
  always_comb begin
    sel = SEL_NONE;
    if (!reset) begin
      if (state_q == ST_ARB) begin
        case (ptr_q)
          PT_RD: begin
            if (rd_req)       sel = SEL_RD;
            else if (cpu_req) sel = SEL_CPU;
            else if (wr_req)  sel = SEL_WR;
          end
          PT_CPU: begin
            if (cpu_req)      sel = SEL_CPU;
            else if (wr_req)  sel = SEL_WR;
            else if (rd_req)  sel = SEL_RD;
          end
          default: begin
            if (wr_req)       sel = SEL_WR;
            else if (rd_req)  sel = SEL_RD;
            else if (cpu_req) sel = SEL_CPU;
          end
        endcase
      end else if (cpu_req) begin
        sel = SEL_CPU;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    tag1_d       = TAG_NONE;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;

    case (state_q)
      ST_ARB:    if (cpu_lock) state_d = ST_DRAIN;
      // tag1 is the access on the SRAM pins now; once it is not wr/rd nothing
      // from those ports touches the array after this cycle.
      ST_DRAIN: begin
        if (!cpu_lock)                                 state_d = ST_ARB;
        else if (tag1_q != TAG_WR && tag1_q != TAG_RD) state_d = ST_LOCKED;
      end
      ST_LOCKED: if (!cpu_lock) state_d = ST_ARB;
      default:   state_d = ST_ARB;
    endcase

    if (state_q == ST_ARB) begin
      if (two_plus && cnt_q != '1) cnt_d = cnt_q + 16'd1;
      case (sel)
        SEL_WR:  ptr_d = PT_RD;
        SEL_RD:  ptr_d = PT_CPU;
        SEL_CPU: ptr_d = PT_WR;
        default: ptr_d = ptr_q;
      endcase
    end

    case (sel)
      SEL_WR: begin
        tag1_d       = TAG_WR;
        sram_en_d    = 1'b1;
        sram_we_d    = 1'b1;
        sram_addr_d  = wr_addr;
        sram_wdata_d = wr_wdata;
      end
      SEL_RD: begin
        tag1_d      = TAG_RD;
        sram_en_d   = 1'b1;
        sram_addr_d = rd_addr;
      end
      SEL_CPU: begin
        tag1_d      = cpu_wen ? TAG_CPU_WR : TAG_CPU_RD;
        sram_en_d   = 1'b1;
        sram_we_d   = cpu_wen;
        sram_addr_d = cpu_addr;
        if (cpu_wen) sram_wdata_d = cpu_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ARB;
      ptr_q        <= PT_WR;
      cnt_q        <= '0;
      tag1_q       <= TAG_NONE;
      tag2_q       <= TAG_NONE;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag1_q;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign wr_gnt       = (sel == SEL_WR);
  assign rd_gnt       = (sel == SEL_RD);
  assign cpu_gnt      = (sel == SEL_CPU);
  assign rd_rvld      = (tag2_q == TAG_RD);
  assign cpu_rvld     = (tag2_q == TAG_CPU_RD);
  assign rd_rdata     = rd_rvld  ? sram_rdata : '0;
  assign cpu_rdata    = cpu_rvld ? sram_rdata : '0;
  assign locked       = (state_q == ST_LOCKED);
  assign conflict_cnt = cnt_q;
  assign sram_en      = sram_en_q;
  assign sram_we      = sram_we_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios then random traffic,
// all checked against a cycle-level behavioural model with a shadow memory.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req, rd_req, cpu_req, cpu_wen, cpu_lock;
  logic [7:0]  wr_addr, rd_addr, cpu_addr;
  logic [71:0] wr_wdata, cpu_wdata;
  logic        wr_gnt, rd_gnt, cpu_gnt, rd_rvld, cpu_rvld, locked;
  logic [71:0] rd_rdata, cpu_rdata;
  logic [15:0] conflict_cnt;
  logic        sram_en, sram_we;
  logic [7:0]  sram_addr;
  logic [71:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rdata(rd_rdata), .rd_rvld(rd_rvld),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvld(cpu_rvld),
    .cpu_lock(cpu_lock), .locked(locked), .conflict_cnt(conflict_cnt),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM macro: 1-cycle read latency, contents survive reset
  bit [71:0] mem [256];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: port ids 0=wr 1=rd 2=cpu, mode 0=arb 1=drain 2=locked
  typedef struct {
    int          who;
    bit          rd;
    logic [7:0]  addr;
    logic [71:0] data;
  } rec_t;

  int          m_mode, m_ptr, m_g, m_last_g;
  int unsigned m_cnt;
  rec_t        p1, p2;
  logic [7:0]  m_addr;
  logic [71:0] m_wdata;
  bit   [71:0] shadow [256];

  function automatic rec_t idle_rec();
    rec_t r;
    r.who = -1; r.rd = 1'b0; r.addr = '0; r.data = '0;
    return r;
  endfunction

  function automatic bit req_of(input int i);
    return (i == 0) ? wr_req : (i == 1) ? rd_req : cpu_req;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_cnt = 0; m_last_g = -1;
    p1 = idle_rec(); p2 = idle_rec();
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_grant();
    m_g = -1;
    if (!reset) begin
      if (m_mode != 0) begin
        if (cpu_req) m_g = 2;
      end else begin
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (m_ptr + k) % 3;
          if (m_g < 0 && req_of(i)) m_g = i;
        end
      end
    end
  endtask

  task automatic check_all();
    bit exp_en, exp_rdv, exp_cpv;
    exp_en  = (p1.who >= 0);
    exp_rdv = (p2.who == 1);
    exp_cpv = (p2.who == 2) && p2.rd;
    check_eq("wr_gnt",  72'(wr_gnt),  72'(m_g == 0));
    check_eq("rd_gnt",  72'(rd_gnt),  72'(m_g == 1));
    check_eq("cpu_gnt", 72'(cpu_gnt), 72'(m_g == 2));
    check_eq("sram_en", 72'(sram_en), 72'(exp_en));
    check_eq("sram_we", 72'(sram_we), 72'(exp_en && !p1.rd));
    if (exp_en) check_eq("sram_addr", 72'(sram_addr), 72'(m_addr));
    if (exp_en && !p1.rd) check_eq("sram_wdata", sram_wdata, m_wdata);
    check_eq("rd_rvld",  72'(rd_rvld),  72'(exp_rdv));
    check_eq("cpu_rvld", 72'(cpu_rvld), 72'(exp_cpv));
    if (exp_rdv) check_eq("rd_rdata",  rd_rdata,  p2.data);
    if (exp_cpv) check_eq("cpu_rdata", cpu_rdata, p2.data);
    check_eq("locked",  72'(locked), 72'(m_mode == 2));
    check_eq("conflict_cnt", 72'(conflict_cnt), 72'(m_cnt));
  endtask

  task automatic model_update();
    rec_t r;
    int   n;
    if (reset) begin
      model_reset();
      return;
    end
    n = int'(wr_req) + int'(rd_req) + int'(cpu_req);
    if (m_mode == 0 && n >= 2 && m_cnt < 65535) m_cnt++;
    r = idle_rec();
    r.who = m_g;
    if (m_g == 0) begin
      r.addr = wr_addr; r.data = wr_wdata;
    end else if (m_g == 1) begin
      r.rd = 1'b1; r.addr = rd_addr;
    end else if (m_g == 2) begin
      r.rd = !cpu_wen; r.addr = cpu_addr; r.data = cpu_wdata;
    end
    if (m_g >= 0) begin
      m_addr = r.addr;
      if (r.rd) r.data = shadow[r.addr];
      else begin
        shadow[r.addr] = r.data;
        m_wdata = r.data;
      end
      if (m_mode == 0) m_ptr = (m_g + 1) % 3;
    end
    case (m_mode)
      0: if (cpu_lock) m_mode = 1;
      1: begin
        if (!cpu_lock) m_mode = 0;
        else if (p1.who != 0 && p1.who != 1) m_mode = 2;
      end
      default: if (!cpu_lock) m_mode = 0;
    endcase
    p2 = p1;
    p1 = r;
    m_last_g = m_g;
  endtask

  task automatic tick();
    #1;
    model_grant();
    check_all();
    model_update();
    @(negedge clk);
  endtask

  int          exp_seq [6] = '{0, 1, 2, 0, 1, 2};
  logic [71:0] t1_data = 72'h11_0123456789ABCDEF;

  initial begin
    reset = 1'b1;
    wr_req = 0; rd_req = 0; cpu_req = 0; cpu_wen = 0; cpu_lock = 0;
    wr_addr = '0; rd_addr = '0; cpu_addr = '0; wr_wdata = '0; cpu_wdata = '0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // single write from reset
    wr_req = 1; wr_addr = 8'h05; wr_wdata = t1_data;
    #1 check_eq("t1_wr_gnt", 72'(wr_gnt), 72'(1));
    tick();
    wr_req = 0;
    #1;
    check_eq("t1_sram_en", 72'(sram_en), 72'(1));
    check_eq("t1_sram_we", 72'(sram_we), 72'(1));
    check_eq("t1_sram_addr", 72'(sram_addr), 72'(8'h05));
    check_eq("t1_sram_wdata", sram_wdata, t1_data);
    tick();

    // CPU read-back
    cpu_req = 1; cpu_wen = 0; cpu_addr = 8'h05;
    #1 check_eq("t2_cpu_gnt", 72'(cpu_gnt), 72'(1));
    tick();
    cpu_req = 0;
    tick();
    #1;
    check_eq("t2_cpu_rvld", 72'(cpu_rvld), 72'(1));
    check_eq("t2_cpu_rdata", cpu_rdata, t1_data);
    check_eq("t2_rd_rvld", 72'(rd_rvld), 72'(0));
    tick();

    // three requesters held for six cycles
    wr_req = 1; rd_req = 1; cpu_req = 1; cpu_wen = 0;
    wr_addr = 8'h10; wr_wdata = 72'hA5_5A5A5A5A5A5A5A5A; rd_addr = 8'h10; cpu_addr = 8'h05;
    for (int i = 0; i < 6; i++) begin
      #1 check_eq("t3_order", 72'({cpu_gnt, rd_gnt, wr_gnt}), 72'(3'b001 << exp_seq[i]));
      tick();
    end
    wr_req = 0; rd_req = 0; cpu_req = 0;
    #1 check_eq("t3_conflict_cnt", 72'(conflict_cnt), 72'(6));
    tick();
    tick();
    tick();

    // lock raised right after a read grant
    rd_req = 1; rd_addr = 8'h05;
    #1 check_eq("t4_rd_gnt", 72'(rd_gnt), 72'(1));
    tick();
    rd_req = 0; cpu_lock = 1;
    tick();
    wr_req = 1; wr_addr = 8'h33; wr_wdata = 72'h77_FEEDFACECAFEBEEF;
    rd_req = 1; rd_addr = 8'h10;
    cpu_req = 1; cpu_wen = 1; cpu_addr = 8'h20; cpu_wdata = 72'h3C_0011223344556677;
    #1;
    check_eq("t4_rd_rvld", 72'(rd_rvld), 72'(1));
    check_eq("t4_rd_rdata", rd_rdata, t1_data);
    tick();
    #1 check_eq("t4_locked", 72'(locked), 72'(1));
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t4_wr_excl", 72'(wr_gnt), 72'(0));
      check_eq("t4_rd_excl", 72'(rd_gnt), 72'(0));
      check_eq("t4_cpu_gnt", 72'(cpu_gnt), 72'(1));
      tick();
    end

    // release: pointer stored as CPU, so WR then RD
    cpu_lock = 0; cpu_req = 0;
    tick();
    #1;
    check_eq("t5_unlocked", 72'(locked), 72'(0));
    check_eq("t5_wr_first", 72'(wr_gnt), 72'(1));
    tick();
    wr_req = 0;
    #1 check_eq("t5_rd_second", 72'(rd_gnt), 72'(1));
    tick();
    rd_req = 0;
    tick();
    tick();

    // reset the cycle after a read grant
    rd_req = 1; rd_addr = 8'h33;
    #1 check_eq("t6_rd_gnt", 72'(rd_gnt), 72'(1));
    tick();
    rd_req = 0; reset = 1;
    tick();
    reset = 0;
    #1;
    check_eq("t6_rd_rvld", 72'(rd_rvld), 72'(0));
    check_eq("t6_sram_en", 72'(sram_en), 72'(0));
    check_eq("t6_conflict_cnt", 72'(conflict_cnt), 72'(0));
    check_eq("t6_locked", 72'(locked), 72'(0));
    tick();
    #1 check_eq("t6_rd_rvld_late", 72'(rd_rvld), 72'(0));
    tick();

    // random traffic; requesters hold until granted
    for (int c = 0; c < 3000; c++) begin
      if (wr_req && m_last_g == 0) wr_req = 0;
      if (rd_req && m_last_g == 1) rd_req = 0;
      if (cpu_req && m_last_g == 2) cpu_req = 0;
      if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1; wr_addr = 8'($urandom_range(0, 15));
        wr_wdata = {8'($urandom), $urandom, $urandom};
      end
      if (!rd_req && $urandom_range(0, 2) == 0) begin
        rd_req = 1; rd_addr = 8'($urandom_range(0, 15));
      end
      if (!cpu_req) begin
        cpu_wen = 1'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          cpu_req = 1; cpu_addr = 8'($urandom_range(0, 15));
          cpu_wdata = {8'($urandom), $urandom, $urandom};
        end
      end
      if ($urandom_range(0, 39) == 0) cpu_lock = ~cpu_lock;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
